// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_pkg
// Brief   : Shared state encoding and sizing constants for serial_adder_ctrl.
// Revision: 1.0
// ============================================================================
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;
    localparam int SA_CNT_W         = $clog2(SA_DEFAULT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder_halfadder.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_halfadder
// Brief   : One-bit full adder built from two half adders.
// Revision: 1.0
// ============================================================================
module full_adder_halfadder (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic c
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = a ^ b;
    assign w_c1 = a & b;
    assign s    = w_s1 ^ c;
    assign w_c2 = w_s1 & c;
    assign co   = w_c1 | w_c2;

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : serial_adder_ctrl
// Brief   : Bit-serial add/subtract, LSB first, one bit per clock.
// Revision: 1.0
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // The shared constant is sized for the default width; wider builds resize.
    localparam int               CNT_W  = (WIDTH == SA_DEFAULT_WIDTH) ? SA_CNT_W
                                                                      : $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    sa_state_t        r_state;
    sa_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic             w_start_ok;

    assign w_start_ok = start && (r_state != RUN);
    assign w_last     = (r_state == RUN) && (r_cnt == C_LAST);

    full_adder_halfadder u_fa (
        .s  (w_s),
        .co (w_co),
        .a  (r_a[0]),
        .b  (r_b[0]),
        .c  (r_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Result bits enter at the MSB and shift down, landing in place after WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_start_ok) begin
            r_a     <= op_a;
            r_b     <= sub ? ~op_b : op_b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= r_carry ^ w_co;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation; sampled only while busy=0.
REQ-005 The block SHALL have port sub, input, 1 bit: 0 selects a+b+cin, 1 selects a-b; sampled with start.
REQ-006 The block SHALL have ports op_a and op_b, inputs, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out; for sub, 1 means no borrow.
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, through one full-adder cell, one bit per clock.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; busy=1 exactly in RUN.
REQ-015 In IDLE or DONE, start=1 at a rising edge (edge 0) SHALL capture op_a, the effective B, the initial carry, clear the bit counter and enter RUN.
REQ-016 Effective B SHALL be op_b when sub=0 and ~op_b when sub=1; initial carry SHALL be cin when sub=0 and 1 when sub=1.
REQ-017 On each edge in RUN, bit i SHALL be summed: sum bit written, carry register updated, operand registers shifted and counter incremented.
REQ-018 On edge WIDTH the last bit SHALL be written, cout and ovf registered, the state set to DONE, done set to 1 and busy set to 0.
REQ-019 Latency SHALL be exactly WIDTH cycles from the start-sampling edge to done high; done SHALL stay high exactly one cycle.
REQ-020 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 sum, cout and ovf SHALL hold their last values until the next operation's final edge; intermediate sum bits MAY change during RUN.
REQ-022 start SHALL be ignored while busy=1; the operation in progress SHALL not be disturbed, and operand, sub or cin changes SHALL have no effect.
REQ-023 start=1 in DONE SHALL begin a new operation on that edge (back-to-back throughput: one result per WIDTH+1 cycles); otherwise DONE SHALL return to IDLE.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE and busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the counter width constant $clog2(WIDTH+1) computed from the default WIDTH.
REQ-027 The block SHALL instantiate exactly one full_adder_halfadder (ports s, co, a, b, c) as its arithmetic cell; no other sub-module is required.

Verification
REQ-028 WIDTH=8, op_a=0x0F, op_b=0x01, sub=0, cin=0 -> done 8 cycles after start; sum=0x10, cout=0, ovf=0; busy high for exactly 8 cycles.
REQ-029 op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; op_a=0x7F, op_b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-030 sub=1, op_a=0x05, op_b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0; sub=1, op_a=0x80, op_b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-031 start pulsed again at cycle 3 of RUN with different operands -> ignored; the original result is unchanged and there is a single done.
REQ-032 rst_n driven low at cycle 4 of RUN, between clock edges -> outputs are 0 immediately and no done pulse follows; a new operation after release is correct.
REQ-033 start held high through DONE -> a second operation starts on the DONE edge; the second done is exactly 9 cycles after the first.
